// File: rtl/red_pitaya_daisy_rx_par.sv
// Daisy-chain parallel receiver: frames 4-nibble words from the deserializer, trains word
// alignment against a fixed pattern (requesting bitslips as needed), then delivers data words
// or counts training errors once locked.
module red_pitaya_daisy_rx_par #(
  parameter logic [15:0] TRAIN_PAT = 16'h00FF,
  parameter int unsigned LOCK_N    = 4,
  parameter int unsigned HUNT_TO   = 8
) (
  input  logic        par_clk_i,
  input  logic        par_rstn_i,
  input  logic [3:0]  ser_nib_i,
  input  logic        cfg_train_i,
  input  logic        err_clr_i,
  output logic        bitslip_o,
  output logic        locked_o,
  output logic        par_dv_o,
  output logic [15:0] par_dat_o,
  output logic [15:0] err_cnt_o
);

  localparam int unsigned MatchW = $clog2(LOCK_N + 1);
  localparam int unsigned IdleW  = $clog2(HUNT_TO + 1);
  localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_N - 1);
  localparam logic [IdleW-1:0]  IdleLast  = IdleW'(HUNT_TO - 1);

  typedef enum logic [1:0] {StHunt, StSlipWait, StCheck, StLocked} state_e;

  state_e            state_q, state_d;
  logic [15:0]       sh_q;
  logic [1:0]        fc_q, fc_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic [MatchW-1:0] match_q, match_d;
  logic [1:0]        miss_q, miss_d;
  logic [1:0]        slip_q, slip_d;
  logic              bitslip_q, bitslip_d;
  logic              locked_q, locked_d;
  logic              dv_q, dv_d;
  logic [15:0]       dat_q, dat_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  logic [15:0] word;
  logic        word_hit;
  logic        boundary;
  logic        err_inc;

  // Candidate word ends with the nibble currently on the input.
  assign word     = {ser_nib_i, sh_q[15:4]};
  assign word_hit = (word == TRAIN_PAT);
  assign boundary = (fc_q == 2'd3);

  // Next-state logic for alignment FSM, framing and output registers.
  always_comb begin
    state_d   = state_q;
    fc_d      = fc_q + 2'd1;
    idle_d    = idle_q;
    match_d   = match_q;
    miss_d    = miss_q;
    slip_d    = slip_q;
    bitslip_d = 1'b0;
    dv_d      = 1'b0;
    dat_d     = dat_q;
    err_inc   = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (!cfg_train_i) begin
          idle_d = '0;
        end else if (word_hit) begin
          // Realign framing so the matched word ends on a boundary.
          fc_d    = 2'd0;
          match_d = MatchW'(1);
          idle_d  = '0;
          state_d = StCheck;
        end else if (idle_q == IdleLast) begin
          idle_d    = '0;
          bitslip_d = 1'b1;
          slip_d    = 2'd0;
          state_d   = StSlipWait;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end
      StSlipWait: begin
        // Let the deserializer apply the slip before hunting again.
        idle_d = '0;
        if (slip_q == 2'd2) begin
          slip_d  = 2'd0;
          state_d = StHunt;
        end else begin
          slip_d = slip_q + 2'd1;
        end
      end
      StCheck: begin
        if (!cfg_train_i) begin
          state_d = StHunt;
        end else if (boundary) begin
          if (!word_hit) begin
            state_d = StHunt;
          end else if (match_q == MatchLast) begin
            miss_d  = 2'd0;
            state_d = StLocked;
          end else begin
            match_d = match_q + MatchW'(1);
          end
        end
      end
      StLocked: begin
        if (boundary) begin
          if (cfg_train_i) begin
            if (word_hit) begin
              miss_d = 2'd0;
            end else begin
              err_inc = 1'b1;
              if (miss_q == 2'd2) begin
                miss_d  = 2'd0;
                state_d = StHunt;
              end else begin
                miss_d = miss_q + 2'd1;
              end
            end
          end else if (word != 16'h0000) begin
            // All-zero word is link idle, not data.
            dat_d = word;
            dv_d  = 1'b1;
          end
        end
      end
      default: state_d = StHunt;
    endcase

    if (err_clr_i) begin
      err_cnt_d = 16'h0000;
    end else if (err_inc && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end

    locked_d = (state_d == StLocked);
  end

  // State and datapath registers.
  always_ff @(posedge par_clk_i or negedge par_rstn_i) begin
    if (!par_rstn_i) begin
      state_q   <= StHunt;
      sh_q      <= '0;
      fc_q      <= '0;
      idle_q    <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      dv_q      <= 1'b0;
      dat_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sh_q      <= word;
      fc_q      <= fc_d;
      idle_q    <= idle_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      slip_q    <= slip_d;
      bitslip_q <= bitslip_d;
      locked_q  <= locked_d;
      dv_q      <= dv_d;
      dat_q     <= dat_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bitslip_o = bitslip_q;
  assign locked_o  = locked_q;
  assign par_dv_o  = dv_q;
  assign par_dat_o = dat_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_red_pitaya_daisy_rx_par.sv
// Bench for red_pitaya_daisy_rx_par: training lock, bitslip hunting against a bit-level
// deserializer model, data delivery through a scoreboard, error counting and reset.
module tb_red_pitaya_daisy_rx_par;

  localparam logic [15:0] TrainPat = 16'h00FF;
  localparam int unsigned HuntTo   = 8;
  localparam logic [15:0] BadWord  = 16'h00FE;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  ser_nib = 4'h0;
  logic        cfg_train = 1'b0;
  logic        err_clr = 1'b0;
  logic        bitslip_o;
  logic        locked_o;
  logic        par_dv_o;
  logic [15:0] par_dat_o;
  logic [15:0] err_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int slips = 0;
  logic [15:0] sb[$];
  logic [15:0] tp = TrainPat;

  red_pitaya_daisy_rx_par #(
    .TRAIN_PAT(TrainPat),
    .LOCK_N   (4),
    .HUNT_TO  (HuntTo)
  ) dut (
    .par_clk_i  (clk),
    .par_rstn_i (rstn),
    .ser_nib_i  (ser_nib),
    .cfg_train_i(cfg_train),
    .err_clr_i  (err_clr),
    .bitslip_o  (bitslip_o),
    .locked_o   (locked_o),
    .par_dv_o   (par_dv_o),
    .par_dat_o  (par_dat_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive a nibble, sample 1 time unit after the edge, score any output word.
  task automatic step(input logic [3:0] nib);
    logic [15:0] exp;
    ser_nib = nib;
    @(posedge clk);
    #1;
    cyc++;
    if (bitslip_o) slips++;
    if (par_dv_o) begin
      if (sb.size() == 0) begin
        check_eq("dv_spurious", 32'(par_dv_o), 32'd0);
      end else begin
        exp = sb.pop_front();
        check_eq("sb_dat", 32'(par_dat_o), 32'(exp));
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic clr_last);
    for (int i = 0; i < 4; i++) begin
      err_clr = (i == 3) ? clr_last : 1'b0;
      step(w[4*i +: 4]);
    end
    err_clr = 1'b0;
  endtask

  task automatic data_word(input logic [15:0] w);
    if (w != 16'h0000) sb.push_back(w);
    for (int i = 0; i < 4; i++) begin
      step(w[4*i +: 4]);
      if (i == 0) check_eq("dv_width", 32'(par_dv_o), 32'd0);
    end
    check_eq("dv_lat", 32'(par_dv_o), 32'(w != 16'h0000));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_locked"}, 32'(locked_o), 32'd0);
    check_eq({tag, "_dv"}, 32'(par_dv_o), 32'd0);
    check_eq({tag, "_dat"}, 32'(par_dat_o), 32'd0);
    check_eq({tag, "_err"}, 32'(err_cnt_o), 32'd0);
    check_eq({tag, "_slip"}, 32'(bitslip_o), 32'd0);
  endtask

  // Train from word phase 0; lock must appear exactly after the 16th nibble.
  task automatic train_lock(input string tag);
    for (int n = 1; n <= 16; n++) begin
      step(tp[4*((n-1)%4) +: 4]);
      if (n == 15) check_eq({tag, "_early"}, 32'(locked_o), 32'd0);
      if (n == 16) check_eq({tag, "_lock"}, 32'(locked_o), 32'd1);
    end
  endtask

  initial begin
    int s0;
    int pos;
    int nslip;
    int last_slip;
    logic [3:0] nib;
    logic [15:0] w;

    // Reset state
    #12;
    check_all_zero("rst");
    #3 rstn = 1'b1;

    // Training off in HUNT: no bitslip, no lock
    for (int i = 0; i < 20; i++) step(4'($urandom_range(0, 15)));
    check_eq("hunt_noslip", 32'(slips), 32'd0);
    check_eq("hunt_nolock", 32'(locked_o), 32'd0);

    // Aligned training stream locks with no bitslip
    cfg_train = 1'b1;
    s0 = slips;
    train_lock("aligned");
    check_eq("aligned_noslip", 32'(slips - s0), 32'd0);

    // Data delivery with training off; lock must survive the toggle
    cfg_train = 1'b0;
    data_word(16'h1234);
    check_eq("dat_1234", 32'(par_dat_o), 32'h1234);
    data_word(16'h0000);
    check_eq("idle_hold", 32'(par_dat_o), 32'h1234);
    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom) | 16'h0100;
      data_word(w);
    end
    data_word(16'h0000);
    check_eq("train_off_locked", 32'(locked_o), 32'd1);

    // Single corrupted training word
    cfg_train = 1'b1;
    send_word(tp, 1'b0);
    check_eq("train_on_locked", 32'(locked_o), 32'd1);
    send_word(BadWord, 1'b0);
    check_eq("err_one", 32'(err_cnt_o), 32'd1);
    check_eq("err_one_locked", 32'(locked_o), 32'd1);
    send_word(tp, 1'b0);

    // Saturation and clear priority
    force dut.err_cnt_q = 16'hFFFE;
    #2;
    release dut.err_cnt_q;
    send_word(BadWord, 1'b0);
    check_eq("err_to_max", 32'(err_cnt_o), 32'hFFFF);
    send_word(tp, 1'b0);
    send_word(BadWord, 1'b0);
    check_eq("err_sat", 32'(err_cnt_o), 32'hFFFF);
    send_word(tp, 1'b0);
    send_word(BadWord, 1'b1);
    check_eq("err_clr_prio", 32'(err_cnt_o), 32'd0);
    check_eq("clr_locked", 32'(locked_o), 32'd1);
    send_word(tp, 1'b0);

    // Three consecutive misses drop lock
    send_word(BadWord, 1'b0);
    check_eq("miss1_locked", 32'(locked_o), 32'd1);
    send_word(BadWord, 1'b0);
    check_eq("miss2_locked", 32'(locked_o), 32'd1);
    send_word(BadWord, 1'b0);
    check_eq("miss3_unlock", 32'(locked_o), 32'd0);
    check_eq("miss3_err", 32'(err_cnt_o), 32'd3);

    // Relock from HUNT
    for (int k = 1; k <= 4; k++) begin
      send_word(tp, 1'b0);
      check_eq("relock", 32'(locked_o), 32'(k == 4));
    end

    // Asynchronous reset while locked and mid-word
    cfg_train = 1'b0;
    data_word(16'hBEEF);
    step(4'h1);
    step(4'h2);
    #3 rstn = 1'b0;
    #1;
    check_all_zero("arst");
    #3 rstn = 1'b1;
    cfg_train = 1'b1;
    train_lock("post_rst");
    check_eq("post_rst_err", 32'(err_cnt_o), 32'd0);

    // Bit-misaligned stream: deserializer model slips one bit per request
    #3 rstn = 1'b0;
    #3 rstn = 1'b1;
    pos = 1;
    nslip = 0;
    last_slip = -1;
    for (int c = 0; c < 200; c++) begin
      for (int k = 0; k < 4; k++) nib[k] = tp[(pos + k) % 16];
      step(nib);
      pos = (pos + 4) % 16;
      if (bitslip_o) begin
        if (last_slip >= 0) check_eq("slip_gap", 32'(cyc - last_slip), 32'(HuntTo + 3));
        last_slip = cyc;
        pos = (pos + 1) % 16;
        nslip++;
      end
      if (locked_o) break;
    end
    check_eq("slip_count", 32'(nslip), 32'd3);
    check_eq("slip_lock", 32'(locked_o), 32'd1);

    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
